s100_mem_master: RTL and testbench
==================================

# s100_mem_master

Bus-initiator side of the S-100 memory interface: accepts single-byte read/write requests from the CPU core over a valid/ready handshake and drives the memory responder's split write/read ports. It also inserts programmable wait states, honours the responder's busy flag, and bounds every access with a timeout. On timeout it returns the floating-bus value 8'hFF with an error flag. The block sits between the 8080 core's bus unit and the S-100 RAM/peripheral responders.

## Interface
- WAIT_STATES, 0: extra cycles inserted between request accept and memory issue (0–15).
- TIMEOUT, 15: max cycles waited for `i_mem_busy` low or `i_mem_rd_ready` high (1–255).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  CPU request present.
- o_req_ready  out  1  block can accept a request.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_addr  in  16  byte address.
- i_req_wdata  in  8  write data.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_rdata  out  8  read data; 8'h00 for writes.
- o_rsp_err  out  1  access timed out.
- o_mem_wr_addr  out  16  memory write address.
- o_mem_wr_data  out  8  memory write data.
- o_mem_wr_enable  out  1  one-cycle write strobe.
- o_mem_rd_addr  out  16  memory read address.
- o_mem_rd_enable  out  1  one-cycle read strobe.
- i_mem_rd_data  in  8  read data from responder.
- i_mem_rd_ready  in  1  read data valid.
- i_mem_busy  in  1  responder cannot accept a strobe this cycle.

## Operation
- **FSM states:** IDLE, WAIT, ISSUE, RD_WAIT, RESP.
- **IDLE:**
  - `o_req_ready` = 1.
  - On `i_req_valid && o_req_ready`, latch write, addr and wdata.
  - Go to WAIT if WAIT_STATES > 0, else to ISSUE.
- **WAIT:** count WAIT_STATES cycles, then go to ISSUE.
- **ISSUE:**
  - Strobe = (state == ISSUE) && !i_mem_busy. This is combinational from the registered state, and only the latched direction's enable fires.
  - Write strobe: next state RESP, err = 0, rdata = 8'h00.
  - Read strobe: next state RD_WAIT; the timeout counter clears.
  - While busy: the timeout counter increments. At TIMEOUT busy cycles go to RESP with err = 1 and rdata = 8'hFF; no strobe is ever issued.
- **RD_WAIT:**
  - On `i_mem_rd_ready`, capture `i_mem_rd_data` and go to RESP.
  - Otherwise increment the counter. At TIMEOUT cycles, respond 8'hFF with err = 1.
  - `i_mem_rd_ready` in the ISSUE cycle is ignored.
- **RESP:**
  - `o_rsp_valid` = 1 for exactly one cycle, then go to IDLE.
  - There is no response backpressure.
- **Address/data outputs:**
  - `o_mem_*_addr` and `o_mem_wr_data` reflect the latched request from accept through RESP, and hold their last value in IDLE.
  - Both address outputs carry the same latched address.
- **Enable exclusivity:** `o_mem_wr_enable` and `o_mem_rd_enable` are never high together, and each is high at most one cycle per request.
- **Reset:**
  - State → IDLE; counters, latches, rdata and err → 0.
  - All outputs are 0 during the reset cycle, including `o_req_ready`.
  - Reset mid-access abandons the access: no response, no further strobe.
- **Counter width:** `$clog2(max(TIMEOUT, WAIT_STATES) + 1)`. The counter saturates and never wraps.

## Timing
- Accept at edge N.
- Write, WAIT_STATES = 0, not busy:
  - wr_enable in cycle N+1.
  - rsp_valid in N+2.
  - ready again in N+3.
- Read, responder ready in the cycle after the strobe:
  - rd_enable in N+1.
  - rd_ready seen in N+2.
  - rsp_valid with data in N+3.
  - ready in N+4.
- Each wait state adds 1 cycle; each busy cycle adds 1 cycle.
- Read timeout: rsp_valid/err in cycle N+2+TIMEOUT+WAIT_STATES.
- Back-to-back throughput: one write per 3 cycles, one read per 4 cycles minimum.

## Structure
- Shared package `s100_pkg` holds:
  - the `s100_master_state_t` enum;
  - `S100_ADDR_W` = 16 and `S100_DATA_W` = 8;
  - `S100_FLOAT_DATA` = 8'hFF.
- Single module; no sub-module is warranted.

## Test plan
- **Write:** write 8'hA5 to 16'h0010, WAIT_STATES = 0, busy = 0 → wr_enable for 1 cycle at N+1 with addr 16'h0010 and data 8'hA5; rsp_valid at N+2 with err = 0.
- **Read:** read 16'h0010, responder returns 8'h3C with rd_ready at N+2 → rsp_valid at N+3 with rdata 8'h3C and err = 0; rd_enable high exactly 1 cycle.
- **Busy, then wait states:**
  - Busy held 4 cycles on a write → the strobe is delayed 4 cycles and issued once.
  - With WAIT_STATES = 2 → an additional 2-cycle shift.
- **Timeout:** TIMEOUT = 5, read with rd_ready never asserted → rsp_valid at N+7 with rdata 8'hFF and err = 1. Busy stuck high → err response with no strobe.
- **Reset mid-access:** reset asserted in RD_WAIT → no rsp_valid; ready = 1 the cycle after reset deasserts; the next request completes normally.
- **Back-to-back:** valid held high across 3 alternating write/read requests → each is accepted only in IDLE, with no overlapping strobes and responses in request order.

Source files
------------

// File: rtl/s100_pkg.sv
// Shared types and constants for the S-100 bus master.
// Imported by the bus master RTL.
package s100_pkg;

  localparam int S100_ADDR_W = 16;
  localparam int S100_DATA_W = 8;
  localparam logic [S100_DATA_W-1:0] S100_FLOAT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } s100_master_state_t;

  function automatic int unsigned s100_max(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/s100_mem_master.sv
// S-100 memory bus initiator: CPU request handshake to split
// write/read responder ports with wait states and timeout.
module s100_mem_master
  import s100_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic                   i_req_write,
  input  logic [S100_ADDR_W-1:0] i_req_addr,
  input  logic [S100_DATA_W-1:0] i_req_wdata,
  output logic                   o_rsp_valid,
  output logic [S100_DATA_W-1:0] o_rsp_rdata,
  output logic                   o_rsp_err,
  output logic [S100_ADDR_W-1:0] o_mem_wr_addr,
  output logic [S100_DATA_W-1:0] o_mem_wr_data,
  output logic                   o_mem_wr_enable,
  output logic [S100_ADDR_W-1:0] o_mem_rd_addr,
  output logic                   o_mem_rd_enable,
  input  logic [S100_DATA_W-1:0] i_mem_rd_data,
  input  logic                   i_mem_rd_ready,
  input  logic                   i_mem_busy
);

  localparam int unsigned CNT_TOP =
    s100_max(TIMEOUT, WAIT_STATES);
  localparam int unsigned CNT_W = $clog2(CNT_TOP + 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WS_LAST =
    CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  s100_master_state_t r_state, w_state_n;
  logic [CNT_W-1:0]       r_cnt, w_cnt_n, w_cnt_inc;
  logic                   r_write;
  logic [S100_ADDR_W-1:0] r_addr;
  logic [S100_DATA_W-1:0] r_wdata;
  logic [S100_DATA_W-1:0] r_rdata;
  logic                   r_err;
  logic                   w_rsp_ld;
  logic [S100_DATA_W-1:0] w_rsp_data;
  logic                   w_rsp_err;
  logic                   w_accept;
  logic                   w_strobe;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
  assign w_strobe  = (r_state == ST_ISSUE) && !i_mem_busy;

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_rsp_ld   = 1'b0;
    w_rsp_data = '0;
    w_rsp_err  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_cnt_n   = '0;
          w_state_n = (WAIT_STATES > 0) ? ST_WAIT : ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == WS_LAST) begin
          w_cnt_n   = '0;
          w_state_n = ST_ISSUE;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      ST_ISSUE: begin
        if (!i_mem_busy) begin
          w_cnt_n = '0;
          if (r_write) begin
            w_state_n = ST_RESP;
            w_rsp_ld  = 1'b1;
          end else begin
            w_state_n = ST_RD_WAIT;
          end
        end else if (r_cnt == TO_LAST) begin
          w_state_n  = ST_RESP;
          w_rsp_ld   = 1'b1;
          w_rsp_data = S100_FLOAT_DATA;
          w_rsp_err  = 1'b1;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      ST_RD_WAIT: begin
        if (i_mem_rd_ready) begin
          w_state_n  = ST_RESP;
          w_rsp_ld   = 1'b1;
          w_rsp_data = i_mem_rd_data;
        end else if (r_cnt == TO_LAST) begin
          w_state_n  = ST_RESP;
          w_rsp_ld   = 1'b1;
          w_rsp_data = S100_FLOAT_DATA;
          w_rsp_err  = 1'b1;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      ST_RESP: w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_accept) begin
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      if (w_rsp_ld) begin
        r_rdata <= w_rsp_data;
        r_err   <= w_rsp_err;
      end
    end
  end

  // Every output is forced low while reset is held.
  assign o_req_ready     = !i_reset && (r_state == ST_IDLE);
  assign o_rsp_valid     = !i_reset && (r_state == ST_RESP);
  assign o_rsp_rdata     = i_reset ? '0 : r_rdata;
  assign o_rsp_err       = !i_reset && r_err;
  assign o_mem_wr_addr   = i_reset ? '0 : r_addr;
  assign o_mem_rd_addr   = i_reset ? '0 : r_addr;
  assign o_mem_wr_data   = i_reset ? '0 : r_wdata;
  assign o_mem_wr_enable = !i_reset && w_strobe && r_write;
  assign o_mem_rd_enable = !i_reset && w_strobe && !r_write;

endmodule

// File: tb/tb_s100_mem_master.sv
// Directed self-checking bench for s100_mem_master.
// Three instances cover default, wait-state and short-timeout setups.
module tb_s100_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v2, v5;
  logic        wr;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        busy;

  logic        rdy0, rsp0, err0, we0, re0;
  logic [7:0]  rdat0, wd0;
  logic [15:0] wa0, ra0;
  logic        rdy2, rsp2, err2, we2, re2;
  logic [7:0]  rdat2, wd2;
  logic [15:0] wa2, ra2;
  logic        rdy5, rsp5, err5, we5, re5;
  logic [7:0]  rdat5, wd5;
  logic [15:0] wa5, ra5;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_rd = 0;
  int n_ovl = 0;

  always #5 clk = ~clk;

  s100_mem_master #(.WAIT_STATES(0), .TIMEOUT(15)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(v0), .o_req_ready(rdy0),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata),
    .o_rsp_valid(rsp0), .o_rsp_rdata(rdat0), .o_rsp_err(err0),
    .o_mem_wr_addr(wa0), .o_mem_wr_data(wd0),
    .o_mem_wr_enable(we0),
    .o_mem_rd_addr(ra0), .o_mem_rd_enable(re0),
    .i_mem_rd_data(rd_data), .i_mem_rd_ready(rd_ready),
    .i_mem_busy(busy)
  );

  s100_mem_master #(.WAIT_STATES(2), .TIMEOUT(15)) u_ws (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(v2), .o_req_ready(rdy2),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata),
    .o_rsp_valid(rsp2), .o_rsp_rdata(rdat2), .o_rsp_err(err2),
    .o_mem_wr_addr(wa2), .o_mem_wr_data(wd2),
    .o_mem_wr_enable(we2),
    .o_mem_rd_addr(ra2), .o_mem_rd_enable(re2),
    .i_mem_rd_data(rd_data), .i_mem_rd_ready(rd_ready),
    .i_mem_busy(busy)
  );

  s100_mem_master #(.WAIT_STATES(0), .TIMEOUT(5)) u_to (
    .i_clk(clk), .i_reset(rst),
    .i_req_valid(v5), .o_req_ready(rdy5),
    .i_req_write(wr), .i_req_addr(addr), .i_req_wdata(wdata),
    .o_rsp_valid(rsp5), .o_rsp_rdata(rdat5), .o_rsp_err(err5),
    .o_mem_wr_addr(wa5), .o_mem_wr_data(wd5),
    .o_mem_wr_enable(we5),
    .o_mem_rd_addr(ra5), .o_mem_rd_enable(re5),
    .i_mem_rd_data(rd_data), .i_mem_rd_ready(rd_ready),
    .i_mem_busy(busy)
  );

  always @(posedge clk) begin
    if (we0) n_wr <= n_wr + 1;
    if (re0) n_rd <= n_rd + 1;
    if ((we0 && re0) || (we2 && re2) || (we5 && re5))
      n_ovl <= n_ovl + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  int wr_base, rd_base;
  int acc_idx, rsp_idx;
  bit accepted;
  int acc_cyc[3] = '{0, 3, 7};
  int rsp_cyc[3] = '{2, 6, 9};
  logic [7:0] rsp_dat[3] = '{8'h00, 8'h99, 8'h00};

  initial begin
    rst = 1'b1; v0 = 0; v2 = 0; v5 = 0; wr = 0;
    addr = '0; wdata = '0; rd_data = '0;
    rd_ready = 0; busy = 0;
    tick();
    neg();
    chk("rst_ready", rdy0, 1'b0);
    chk("rst_rsp", rsp0, 1'b0);
    chk("rst_en", {we0, re0}, 2'b00);
    tick();
    rst = 1'b0;
    neg();
    chk("idle_ready", rdy0, 1'b1);
    chk("idle_rdata", rdat0, 8'h00);
    chk("idle_err", err0, 1'b0);
    chk("idle_addr", wa0, 16'h0000);

    // single write
    wr_base = n_wr;
    v0 = 1; wr = 1; addr = 16'h0010; wdata = 8'hA5;
    tick();
    v0 = 0;
    neg();
    chk("w_en", {we0, re0}, 2'b10);
    chk("w_addr", wa0, 16'h0010);
    chk("w_data", wd0, 8'hA5);
    chk("w_busy_ready", rdy0, 1'b0);
    tick();
    neg();
    chk("w_en_off", we0, 1'b0);
    chk("w_rsp", rsp0, 1'b1);
    chk("w_err", err0, 1'b0);
    chk("w_rdata", rdat0, 8'h00);
    tick();
    neg();
    chk("w_ready", rdy0, 1'b1);
    chk("w_rsp_off", rsp0, 1'b0);
    chk("w_pulses", n_wr - wr_base, 1);

    // single read
    rd_base = n_rd;
    v0 = 1; wr = 0; addr = 16'h0010;
    tick();
    v0 = 0;
    neg();
    chk("r_en", {we0, re0}, 2'b01);
    chk("r_addr", ra0, 16'h0010);
    tick();
    rd_ready = 1; rd_data = 8'h3C;
    neg();
    chk("r_en_off", re0, 1'b0);
    chk("r_rsp_early", rsp0, 1'b0);
    tick();
    rd_ready = 0; rd_data = 8'h00;
    neg();
    chk("r_rsp", rsp0, 1'b1);
    chk("r_rdata", rdat0, 8'h3C);
    chk("r_err", err0, 1'b0);
    tick();
    neg();
    chk("r_ready", rdy0, 1'b1);
    chk("r_pulses", n_rd - rd_base, 1);

    // write held off by 4 busy cycles
    wr_base = n_wr;
    busy = 1;
    v0 = 1; wr = 1; addr = 16'h0123; wdata = 8'h5A;
    tick();
    v0 = 0;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("b_hold", we0, 1'b0);
      tick();
    end
    busy = 0;
    neg();
    chk("b_en", we0, 1'b1);
    chk("b_addr", wa0, 16'h0123);
    tick();
    neg();
    chk("b_rsp", {rsp0, err0}, 2'b10);
    tick();
    chk("b_pulses", n_wr - wr_base, 1);

    // two wait states plus 4 busy cycles
    busy = 1;
    v2 = 1; wr = 1; addr = 16'h0456; wdata = 8'hC3;
    tick();
    v2 = 0;
    for (int i = 0; i < 6; i++) begin
      neg();
      chk("ws_hold", we2, 1'b0);
      tick();
      if (i == 5) busy = 0;
    end
    neg();
    chk("ws_en", we2, 1'b1);
    chk("ws_data", wd2, 8'hC3);
    tick();
    neg();
    chk("ws_rsp", {rsp2, err2, we2}, 3'b100);
    tick();

    // read timeout, TIMEOUT = 5
    v5 = 1; wr = 0; addr = 16'hBEEF;
    tick();
    v5 = 0;
    neg();
    chk("to_en", re5, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("to_wait", rsp5, 1'b0);
      tick();
    end
    neg();
    chk("to_rsp", rsp5, 1'b1);
    chk("to_rdata", rdat5, 8'hFF);
    chk("to_err", err5, 1'b1);
    tick();

    // busy stuck high: error, no strobe
    busy = 1;
    v5 = 1; wr = 1; addr = 16'h2222; wdata = 8'h44;
    tick();
    v5 = 0;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("bs_nostrobe", {we5, rsp5}, 2'b00);
      tick();
    end
    neg();
    chk("bs_rsp", {rsp5, err5, we5}, 3'b110);
    chk("bs_rdata", rdat5, 8'hFF);
    tick();
    busy = 0;
    neg();
    chk("bs_ready", rdy5, 1'b1);

    // reset in RD_WAIT abandons the read
    tick();
    v0 = 1; wr = 0; addr = 16'h0777;
    tick();
    v0 = 0;
    neg();
    chk("rr_en", re0, 1'b1);
    tick();
    rst = 1;
    neg();
    chk("rr_in_rst", {rdy0, rsp0, re0, we0}, 4'b0000);
    chk("rr_addr", ra0, 16'h0000);
    tick();
    rst = 0;
    neg();
    chk("rr_ready", rdy0, 1'b1);
    chk("rr_norsp", rsp0, 1'b0);
    tick();
    neg();
    chk("rr_norsp2", {rsp0, re0}, 2'b00);

    // next request completes normally
    v0 = 1; wr = 0; addr = 16'h0777;
    tick();
    v0 = 0;
    neg();
    chk("rn_en", re0, 1'b1);
    tick();
    rd_ready = 1; rd_data = 8'h77;
    tick();
    rd_ready = 0;
    neg();
    chk("rn_rsp", {rsp0, err0}, 2'b10);
    chk("rn_rdata", rdat0, 8'h77);
    tick();

    // back-to-back W, R, W with valid held high
    wr_base = n_wr;
    rd_base = n_rd;
    acc_idx = 0;
    rsp_idx = 0;
    rd_ready = 1; rd_data = 8'h99;
    for (int c = 0; c < 14; c++) begin
      v0 = (acc_idx < 3);
      wr = (acc_idx != 1);
      addr = (acc_idx == 2) ? 16'h0200 : 16'h0100;
      wdata = (acc_idx == 2) ? 8'h22 : 8'h11;
      neg();
      if (rsp0 && rsp_idx < 3) begin
        chk("bb_rsp_cyc", c, rsp_cyc[rsp_idx]);
        chk("bb_rsp_dat", rdat0, rsp_dat[rsp_idx]);
        rsp_idx++;
      end
      accepted = rdy0 && v0;
      if (accepted)
        chk("bb_acc_cyc", c, acc_cyc[acc_idx]);
      tick();
      if (accepted) acc_idx++;
    end
    v0 = 0; rd_ready = 0;
    chk("bb_rsp_count", rsp_idx, 3);
    chk("bb_wr_pulses", n_wr - wr_base, 2);
    chk("bb_rd_pulses", n_rd - rd_base, 1);
    chk("no_overlap", n_ovl, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
